// File: rtl/cabac_bs_feeder_pkg.sv
// Shared constants and helpers for the CABAC bitstream feeder.
package cabac_bs_feeder_pkg;

  localparam int unsigned BS_BUF_W        = 32;
  localparam int unsigned BS_PUSH_MAX     = 24;
  localparam int unsigned BS_VALID_MIN    = 16;
  localparam int unsigned CABAC_INIT_BITS = 9;
  localparam int unsigned BS_CNT_W        = 6;

  localparam logic [7:0] EPB_BYTE     = 8'h03;
  localparam logic [1:0] EPB_ZERO_RUN = 2'd2;

  typedef enum logic [1:0] {RmNone, RmInit, RmAlign, RmConsume} rm_kind_e;

  // Bits needed to reach the next byte boundary from a consumed-bit position.
  function automatic logic [3:0] align_bits(input logic [2:0] pos);
    logic [2:0] amt;
    amt = 3'd0 - pos;
    return {1'b0, amt};
  endfunction

endpackage

// File: rtl/cabac_bs_epb_filter.sv
// Emulation-prevention byte detector: tracks the run of accepted 0x00 bytes and
// strobes drop_o for a 0x03 that follows two of them.
module cabac_bs_epb_filter
  import cabac_bs_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  output logic        drop_o,
  output logic [15:0] epb_cnt_o
);

  logic [1:0]  zrun_q, zrun_d;
  logic [15:0] cnt_q, cnt_d;

  assign drop_o    = accept_i && (byte_i == EPB_BYTE) && (zrun_q == EPB_ZERO_RUN);
  assign epb_cnt_o = cnt_q;

  always_comb begin
    zrun_d = zrun_q;
    cnt_d  = cnt_q;
    if (accept_i) begin
      if (drop_o) begin
        zrun_d = 2'd0;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (byte_i == 8'h00) begin
        zrun_d = (zrun_q == EPB_ZERO_RUN) ? EPB_ZERO_RUN : zrun_q + 2'd1;
      end else begin
        zrun_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zrun_q <= 2'd0;
      cnt_q  <= 16'd0;
    end else begin
      zrun_q <= zrun_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cabac_bs_feeder.sv
// Byte-to-bit feeder for the CABAC engine: 32-bit MSB-aligned shift buffer.
// Emulation-prevention byte removal is built only with CABAC_EPB_REMOVE_EN.
module cabac_bs_feeder
  import cabac_bs_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic [2:0]  i_consume_len,
  input  logic        i_init,
  input  logic        i_byte_align,
  output logic [7:0]  o_rbsp_in,
  output logic [8:0]  o_leading9bits,
  output logic        o_data_valid,
  output logic        o_underflow
`ifdef CABAC_EPB_REMOVE_EN
  ,
  output logic [15:0] o_epb_cnt
`endif
);

  logic [BS_BUF_W-1:0] buf_q, buf_d, buf_mid;
  logic [BS_CNT_W-1:0] cnt_q, cnt_d, cnt_mid;
  logic [2:0]          pos_q, pos_d;
  logic                uf_q, uf_d;
  logic                accept, drop, append;
  rm_kind_e            rm_kind;
  logic [3:0]          rm_req, rm_amt;
  logic                rm_ok;

  assign o_byte_ready   = en && (cnt_q <= BS_CNT_W'(BS_PUSH_MAX));
  assign accept         = i_byte_valid && o_byte_ready;
  assign o_data_valid   = (cnt_q >= BS_CNT_W'(BS_VALID_MIN));
  assign o_rbsp_in      = buf_q[BS_BUF_W-1 -: 8];
  assign o_leading9bits = buf_q[BS_BUF_W-1 -: 9];
  assign o_underflow    = uf_q;
  assign append         = accept && !drop;

`ifdef CABAC_EPB_REMOVE_EN
  cabac_bs_epb_filter u_epb (
    .clk       (clk),
    .rst       (rst),
    .byte_i    (i_byte),
    .accept_i  (accept),
    .drop_o    (drop),
    .epb_cnt_o (o_epb_cnt)
  );
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    rm_kind = RmNone;
    rm_req  = 4'd0;
    if (en) begin
      if (i_init) begin
        rm_kind = RmInit;
        rm_req  = 4'(CABAC_INIT_BITS);
      end else if (i_byte_align) begin
        rm_kind = RmAlign;
        rm_req  = align_bits(pos_q);
      end else if (i_consume_len != 3'd0) begin
        rm_kind = RmConsume;
        rm_req  = {1'b0, i_consume_len};
      end
    end
    case (rm_kind)
      RmInit, RmConsume: rm_ok = o_data_valid;
      RmAlign:           rm_ok = ({2'b00, rm_req} <= cnt_q);
      default:           rm_ok = 1'b1;
    endcase
    rm_amt = rm_ok ? rm_req : 4'd0;
  end

  // Removal and append happen in the same cycle; the new byte lands just
  // below whatever survives the shift.
  always_comb begin
    buf_mid = buf_q << rm_amt;
    cnt_mid = cnt_q - BS_CNT_W'(rm_amt);
    buf_d   = buf_mid;
    cnt_d   = cnt_mid;
    pos_d   = pos_q + rm_amt[2:0];
    uf_d    = uf_q | ((rm_kind != RmNone) && !rm_ok);
    if (append) begin
      buf_d = buf_mid | ({i_byte, 24'd0} >> cnt_mid);
      cnt_d = cnt_mid + BS_CNT_W'(8);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      uf_q  <= uf_d;
    end
  end

endmodule

// File: tb/tb_cabac_bs_feeder.sv
// Directed self-checking bench for cabac_bs_feeder (default or CABAC_EPB_REMOVE_EN build).
module tb_cabac_bs_feeder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_byte_ready;
  logic [2:0] i_consume_len;
  logic       i_init;
  logic       i_byte_align;
  logic [7:0] o_rbsp_in;
  logic [8:0] o_leading9bits;
  logic       o_data_valid;
  logic       o_underflow;
`ifdef CABAC_EPB_REMOVE_EN
  logic [15:0] o_epb_cnt;
`endif

  int n_vec;
  int n_err;

  cabac_bs_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .i_consume_len  (i_consume_len),
    .i_init         (i_init),
    .i_byte_align   (i_byte_align),
    .o_rbsp_in      (o_rbsp_in),
    .o_leading9bits (o_leading9bits),
    .o_data_valid   (o_data_valid),
    .o_underflow    (o_underflow)
`ifdef CABAC_EPB_REMOVE_EN
    ,
    .o_epb_cnt      (o_epb_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    step();
    i_byte_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b1; i_byte = 8'h00; i_byte_valid = 1'b0;
    i_consume_len = 3'd0; i_init = 1'b0; i_byte_align = 1'b0;

    // Reset state
    do_reset();
    chk("rst_rbsp", 16'(o_rbsp_in), 16'h00);
    chk("rst_lead9", 16'(o_leading9bits), 16'h000);
    chk("rst_dv", 16'(o_data_valid), 16'h0);
    chk("rst_ready", 16'(o_byte_ready), 16'h1);
    chk("rst_uf", 16'(o_underflow), 16'h0);
`ifdef CABAC_EPB_REMOVE_EN
    chk("rst_epb", o_epb_cnt, 16'h0000);
`endif

    // Byte offered during reset is dropped
    i_byte = 8'hFF; i_byte_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; i_byte_valid = 1'b0;
    step();
    chk("rstdrop_rbsp", 16'(o_rbsp_in), 16'h00);
    chk("rstdrop_ready", 16'(o_byte_ready), 16'h1);

    // Two bytes -> 16 bits valid
    push(8'hA5);
    push(8'h3C);
    chk("push_dv", 16'(o_data_valid), 16'h1);
    chk("push_rbsp", 16'(o_rbsp_in), 16'hA5);
    chk("push_lead9", 16'(o_leading9bits), 16'h14A);

    // Init removes 9 bits: 7 bits of 0x3C remain
    i_init = 1'b1; i_consume_len = 3'd5;
    step();
    i_init = 1'b0; i_consume_len = 3'd0;
    chk("init_dv", 16'(o_data_valid), 16'h0);
    chk("init_rbsp", 16'(o_rbsp_in), 16'h78);
    chk("init_lead9", 16'(o_leading9bits), 16'h0F0);
    chk("init_uf", 16'(o_underflow), 16'h0);

    // Consume 3 each cycle while pushing FF 00 FF; push stalls at count 26
    do_reset();
    push(8'hFF);
    push(8'h00);
    i_consume_len = 3'd3; i_byte_valid = 1'b1;
    i_byte = 8'hFF; step();
    chk("shift_a", 16'(o_rbsp_in), 16'hF8);
    i_byte = 8'h00; step();
    chk("shift_b", 16'(o_rbsp_in), 16'hC0);
    chk("shift_full_ready", 16'(o_byte_ready), 16'h0);
    i_byte = 8'hFF; step();
    chk("shift_c", 16'(o_rbsp_in), 16'h01);
    chk("shift_ready_back", 16'(o_byte_ready), 16'h1);
    step();
    chk("shift_d", 16'(o_rbsp_in), 16'h0F);
    i_byte_valid = 1'b0; i_consume_len = 3'd0;
    chk("shift_uf", 16'(o_underflow), 16'h0);

    // Consume 5 then align removes 3; a second align removes nothing
    do_reset();
    push(8'hA5);
    push(8'h3C);
    push(8'h0F);
    i_consume_len = 3'd5; step();
    chk("c5_rbsp", 16'(o_rbsp_in), 16'hA7);
    i_byte_align = 1'b1; step();
    chk("align1_rbsp", 16'(o_rbsp_in), 16'h3C);
    chk("align1_dv", 16'(o_data_valid), 16'h1);
    step();
    i_byte_align = 1'b0; i_consume_len = 3'd0;
    chk("align2_rbsp", 16'(o_rbsp_in), 16'h3C);
    chk("align2_lead9", 16'(o_leading9bits), 16'h078);
    chk("align_uf", 16'(o_underflow), 16'h0);

    // Underflow: consume with only 8 bits buffered
    do_reset();
    push(8'hA5);
    i_consume_len = 3'd2; step();
    i_consume_len = 3'd0;
    chk("uf_noshift", 16'(o_rbsp_in), 16'hA5);
    chk("uf_set", 16'(o_underflow), 16'h1);
    push(8'h3C);
    push(8'h0F);
    chk("uf_push_dv", 16'(o_data_valid), 16'h1);
    i_consume_len = 3'd4; step();
    i_consume_len = 3'd0;
    chk("uf_c4_rbsp", 16'(o_rbsp_in), 16'h53);
    chk("uf_sticky", 16'(o_underflow), 16'h1);

    // en = 0 freezes state and blocks the handshake
    do_reset();
    push(8'hA5);
    en = 1'b0; i_byte = 8'h3C; i_byte_valid = 1'b1; i_consume_len = 3'd2;
    #1;
    chk("stall_ready", 16'(o_byte_ready), 16'h0);
    step();
    chk("stall_rbsp", 16'(o_rbsp_in), 16'hA5);
    chk("stall_uf", 16'(o_underflow), 16'h0);
    chk("stall_dv", 16'(o_data_valid), 16'h0);
    en = 1'b1; i_byte_valid = 1'b0; i_consume_len = 3'd0;

    // 00 00 03 01: the 03 is dropped only with emulation-prevention removal
    do_reset();
    push(8'h00);
    push(8'h00);
    push(8'h03);
    push(8'h01);
`ifdef CABAC_EPB_REMOVE_EN
    chk("epb_ready", 16'(o_byte_ready), 16'h1);
    chk("epb_cnt", o_epb_cnt, 16'h0001);
`else
    chk("epb_full_ready", 16'(o_byte_ready), 16'h0);
`endif
    i_consume_len = 3'd7; i_byte = 8'h80; i_byte_valid = 1'b1;
    step();
    i_byte_valid = 1'b0;
    step();
    i_consume_len = 3'd2;
    step();
    i_consume_len = 3'd0;
    chk("epb_dv", 16'(o_data_valid), 16'h1);
    chk("epb_uf", 16'(o_underflow), 16'h0);
`ifdef CABAC_EPB_REMOVE_EN
    chk("epb_rbsp", 16'(o_rbsp_in), 16'h01);
    chk("epb_lead9", 16'(o_leading9bits), 16'h003);
`else
    chk("epb_rbsp", 16'(o_rbsp_in), 16'h03);
    chk("epb_lead9", 16'(o_leading9bits), 16'h006);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
